// File: rtl/rotator_pkg.sv
// Shared types and constants for the rotator sequencer and its sibling rotator.
package rotator_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/rotate_cmd_sequencer.sv
// Turns a free-running single-step rotator into a transactional unit:
// load the word, count N rotation cycles, sample the result, hand it back.
module rotate_cmd_sequencer
  import rotator_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_amount,
  output logic             rot_load,
  output logic             rot_dir,
  output logic [WIDTH-1:0] rot_data,
  input  logic [WIDTH-1:0] rot_q,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q;
  logic             dir_q;
  logic [CNT_W-1:0] amt_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_valid_q;

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rot_load  = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = LOAD;
      end
      LOAD: begin
        rot_load = 1'b1;
        state_d  = WAIT;
      end
      WAIT: if (cnt_q == '0) state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The rotator steps on every non-load edge, so the WAIT edges with
  // cnt!=0 are exactly the requested rotations; rot_q is sampled at cnt==0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      dir_q       <= 1'b0;
      amt_q       <= '0;
      cnt_q       <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (cmd_valid) begin
          data_q <= cmd_data;
          dir_q  <= cmd_dir;
          amt_q  <= cmd_amount;
        end
        LOAD: cnt_q <= amt_q;
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            rsp_data_q  <= rot_q;
            rsp_valid_q <= 1'b1;
          end
        end
        RESP: if (rsp_ready) rsp_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign rot_dir   = dir_q;
  assign rot_data  = data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rotate_cmd_sequencer.sv
// Sequencer wired to a behavioural rotator; stimulus pushes expected results,
// a monitor pops and compares whenever a response is presented.
module tb_rotate_cmd_sequencer;

  localparam int WIDTH = 8;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_data = '0;
  logic             cmd_dir = 1'b0;
  logic [CNT_W-1:0] cmd_amount = '0;
  logic             rot_load, rot_dir;
  logic [WIDTH-1:0] rot_data, rot_q;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [WIDTH-1:0] rsp_data;
  logic             busy;

  rotate_cmd_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .cmd_dir(cmd_dir), .cmd_amount(cmd_amount),
    .rot_load(rot_load), .rot_dir(rot_dir), .rot_data(rot_data), .rot_q(rot_q),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Rotator model: load on load=1, otherwise rotate one bit per edge.
  logic [WIDTH-1:0] rreg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rreg <= '0;
    else if (rot_load) rreg <= rot_data;
    else if (rot_dir) rreg <= {rreg[0], rreg[WIDTH-1:1]};
    else rreg <= {rreg[WIDTH-2:0], rreg[WIDTH-1]};
  end
  assign rot_q = rreg;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               lat;
    int               acc;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // Monitor: checks data and latency on the first cycle of each response.
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (rsp_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_rsp: got data %0h with no pending command", rsp_data);
        end else begin
          chk("rsp_data", rsp_data, exp_q[0].data);
          chk("rsp_latency", cyc - exp_q[0].acc, exp_q[0].lat);
        end
      end
      if (rsp_valid && rsp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      prev_v = rsp_valid;
    end
  end

  task automatic send(input logic [7:0] d, input logic dir, input logic [2:0] amt,
                      input logic [7:0] exp_d, input int lat);
    exp_t e;
    bit   ok = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_data = d; cmd_dir = dir; cmd_amount = amt;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (!ok) begin
      chk_cnt++;
      $display("FAIL cmd_accept: got cmd_ready=0 for 50 cycles, expected 1");
    end else begin
      e.data = exp_d; e.lat = lat; e.acc = cyc;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !busy) begin ok = 1; break; end
    end
    chk("done_idle", ok, 1'b1);
  endtask

  initial begin
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_outs", {rot_load, rot_dir, rot_data, rsp_data}, 18'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    send(8'b10000001, 1'b0, 3'd1, 8'b00000011, 3); wait_done();
    send(8'b10000001, 1'b1, 3'd1, 8'b11000000, 3); wait_done();
    send(8'h01,       1'b1, 3'd7, 8'h02,       9); wait_done();
    send(8'hB4,       1'b0, 3'd3, 8'hA5,       5); wait_done();
    send(8'h5A,       1'b0, 3'd0, 8'h5A,       2); wait_done();
    chk("idle_rot_data_hold", rot_data, 8'h5A);

    // Backpressure in RESP
    rsp_ready = 1'b0;
    send(8'h3C, 1'b0, 3'd2, 8'hF0, 4);
    for (int i = 0; i < 20 && !rsp_valid; i++) begin @(posedge clk); #1; end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin cmd_valid = 1'b1; cmd_data = 8'hFF; cmd_amount = 3'd1; end
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1'b1);
      chk("bp_rsp_data", rsp_data, 8'hF0);
      chk("bp_cmd_ready", cmd_ready, 1'b0);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_idle", busy, 1'b0);
    chk("bp_release_ready", cmd_ready, 1'b1);
    repeat (6) @(posedge clk);
    #1 chk("bp_no_extra_cmd", busy, 1'b0);

    // Reset in the middle of WAIT
    send(8'hC3, 1'b0, 3'd6, 8'h00, 8);
    repeat (2) @(posedge clk);
    #1 chk("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_outs", {rot_load, rot_dir, rot_data, rsp_valid, rsp_data}, 19'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("post_rst_ready", cmd_ready, 1'b1);
    repeat (12) @(posedge clk);
    #1 chk("post_rst_no_rsp", rsp_valid, 1'b0);
    send(8'h81, 1'b0, 3'd1, 8'h03, 3); wait_done();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rotate_cmd_sequencer.md
Name: rotate_cmd_sequencer

Overview:
Upstream command controller for the rotator unit. It accepts one rotate command per transaction through a valid/ready handshake: data word, direction and rotate amount. It drives the rotator's load, dir and data_in pins, counts rotator clock steps, samples the rotator output after exactly the requested number of rotations, and returns the result through a valid/ready response port. It turns the free-running rotator into a transactional functional unit for the datapath.

Parameters:
WIDTH, 8, data word width; must match the rotator width
CNT_W, 3, rotate-amount width; amount range 0..2^CNT_W-1 (equals log2(WIDTH))

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_data  input  WIDTH  word to rotate
cmd_dir  input  1  0 = rotate left, 1 = rotate right
cmd_amount  input  CNT_W  number of single-bit rotations
rot_load  output  1  to rotator load
rot_dir  output  1  to rotator dir
rot_data  output  WIDTH  to rotator data_in
rot_q  input  WIDTH  from rotator data_out
rsp_valid  output  1  result present
rsp_ready  input  1  consumer accepts result
rsp_data  output  WIDTH  rotated word
busy  output  1  high in any state other than IDLE

Behaviour:
- Rotator contract:
  - Rising edge with load=1: register <= data_in.
  - Rising edge with load=0: rotate by 1 in the current dir.
  - The rotator rotates every non-load cycle. The sequencer holds rot_dir stable for the whole transaction.
- State machine: IDLE, LOAD, WAIT, RESP.
- IDLE:
  - cmd_ready=1 (combinational decode of the state).
  - When cmd_valid&cmd_ready is high at an edge, capture data/dir/amount into command registers and go to LOAD.
- LOAD:
  - rot_load=1; rot_data and rot_dir come from the command registers.
  - At the next edge: cnt<=amount, go to WAIT.
- WAIT:
  - rot_load=0.
  - Each edge with cnt!=0: cnt<=cnt-1.
  - Edge with cnt==0: rsp_data<=rot_q (value before the edge), rsp_valid<=1, go to RESP.
- RESP:
  - rsp_valid=1 and rsp_data stay stable until rsp_ready is high at an edge. Then rsp_valid<=0 and the block returns to IDLE.
  - No new command is accepted in the same cycle.
- Latency: with the command accepted at edge H, rsp_valid is high after edge H+2+amount. Examples: amount 0 gives 2 cycles; amount 7 gives 9 cycles.
- rot_data and rot_dir are always driven from the command registers, so they hold their last values in IDLE.
- cmd_ready=0 in LOAD, WAIT and RESP. cmd_valid in those states is ignored, and the command is not consumed.
- Reset (any time, including mid-WAIT or in RESP):
  - state=IDLE, cnt=0, command registers=0.
  - rot_load=0, rot_dir=0, rot_data=0.
  - rsp_valid=0, rsp_data=0, busy=0.
  - cmd_ready=1 after release.
  - Any in-flight transaction is dropped with no response.
- Amount arithmetic: unsigned, no wrap needed because cnt never decrements below 0. Rotate by k modulo WIDTH is implied by the rotator.
- No combinational path from cmd_valid to cmd_ready, or from rsp_ready to rsp_valid.

Decomposition:
- Shared package rotator_pkg:
  - State enum (IDLE, LOAD, WAIT, RESP).
  - DIR_LEFT=1'b0 and DIR_RIGHT=1'b1.
  - Default WIDTH=8.
- No sub-module. The rotator is a sibling instance wired at the parent level and in the bench.

Test Plan:
- Bench configuration: the sequencer wired to the existing rotator, with the same clk/rst.
- Basic left: cmd_data=8'b10000001, dir=0, amount=1, rsp_ready=1 -> rsp_data=8'b00000011, rsp_valid 3 cycles after acceptance, then IDLE.
- Right and wrap: 8'b10000001 dir=1 amount=1 -> 8'b11000000; 8'h01 dir=1 amount=7 -> 8'h02 after 9 cycles.
- Multi-step left and zero amount: 8'hB4 dir=0 amount=3 -> 8'hA5; 8'h5A amount=0 -> 8'h5A with 2-cycle latency.
- Backpressure: rsp_ready held low 5 cycles in RESP -> rsp_valid and rsp_data stay stable, cmd_ready=0, a cmd_valid pulse is not accepted. When rsp_ready rises -> IDLE next cycle.
- Reset mid-operation: assert rst during WAIT of an amount=6 command -> all outputs zero immediately (asynchronous), no response ever appears. A following command 8'h81 left 1 -> 8'h03 is correct.
